piso_reader: RTL

Parallel-in, serial-out reader for the 4-bit hard register bank. Accepts a parallel word over a valid/ready load handshake and shifts it out one bit per enabled cycle. Provides start-of-word and end-of-word markers and a completion pulse. Sits downstream of the register bank and feeds serial links and test scan paths.

---
 rtl/piso_reader_if.sv | 26 ++
 rtl/piso_reader.sv | 101 ++++++++++
 2 files changed

// File: rtl/piso_reader_if.sv
// Load/serial handshake bundle for piso_reader.
// The master side drives the word and flow control; the slave side is the serializer.
interface piso_reader_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] d;
    logic             load_valid;
    logic             load_ready;
    logic             shift_en;
    logic             sout;
    logic             sout_valid;
    logic             sof;
    logic             eof;
    logic             done;
    logic             busy;

    modport master (
        output d, load_valid, shift_en,
        input  load_ready, sout, sout_valid, sof, eof, done, busy
    );

    modport slave (
        input  d, load_valid, shift_en,
        output load_ready, sout, sout_valid, sof, eof, done, busy
    );
endinterface

// File: rtl/piso_reader.sv
// Parallel-in serial-out reader: loads a word over valid/ready, then shifts it out
// one bit per shift_en cycle with start/end markers, a done pulse and an optional idle gap.
module piso_reader #(
    parameter int WIDTH      = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0
) (
    input  logic           clk,
    input  logic           clr,
    piso_reader_if.slave   bus
);
    localparam int                 CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [3:0]         GAP_LAST = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         gap_q, gap_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   sreg_shifted;
    logic               in_shift;

    // Advance toward the output end with zero fill.
    assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, sreg_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_valid) begin
                    sreg_d  = bus.d;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.shift_en) begin
                    if (cnt_q == CNT_LAST) begin
                        done_d = 1'b1;
                        cnt_d  = '0;
                        if (GAP_CYCLES > 0) begin
                            gap_d   = '0;
                            state_d = GAP;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sreg_d = sreg_shifted;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 4'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
        end
    end

    // Serial outputs are decoded from registered state, so they are valid the cycle after capture.
    assign in_shift       = (state_q == SHIFT);
    assign bus.sout       = in_shift & (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);
    assign bus.sout_valid = in_shift;
    assign bus.sof        = in_shift && (cnt_q == '0);
    assign bus.eof        = in_shift && (cnt_q == CNT_LAST);
    assign bus.done       = done_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.load_ready = (state_q == IDLE) && !clr;
endmodule
